// File: rtl/pio_pkg.sv
// pio_pkg: shared constants and helpers for the PIO output shift register.
// Holds the shift-direction encoding, the default register width and the
// "encoded 0 means full width" count decoder used by shift and threshold.
package pio_pkg;

  localparam int   OSR_W_DEFAULT = 32;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Occupancy view of the shift register, derived from the consumed-bit count.
  typedef enum logic [1:0] {
    OSR_EMPTY       = 2'd0,
    OSR_PARTIAL     = 2'd1,
    OSR_FULL_THRESH = 2'd2
  } osr_state_t;

  // Count fields are one bit too narrow to hold W, so 0 stands for W.
  function automatic int unsigned zero_means_w(input int unsigned enc,
                                               input int unsigned w);
    return (enc == 0) ? w : enc;
  endfunction

endpackage

// File: rtl/osr_shifter.sv
// osr_shifter: combinational OUT datapath. Shifts the register by n bits in
// the requested direction and returns the shifted-out bits right-aligned
// with the upper bits zero. n is 1..W; n == W clears the register.
module osr_shifter
  import pio_pkg::*;
#(
  parameter int W  = OSR_W_DEFAULT,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  reg_in,
  input  logic [CW-1:0] n,
  input  logic          dir,
  output logic [W-1:0]  reg_out,
  output logic [W-1:0]  shift_out
);

  logic [W-1:0] low_mask;

  // Shift the register and extract the bits that leave it.
  always_comb begin
    low_mask = ~({W{1'b1}} << n);
    if (dir == DIR_RIGHT) begin
      reg_out   = reg_in >> n;
      shift_out = reg_in & low_mask;
    end else begin
      reg_out   = reg_in << n;
      // Top n bits moved down to bit 0; n == W yields the whole register.
      shift_out = reg_in >> (CW'(W) - n);
    end
    if (n >= CW'(W)) begin
      reg_out = '0;
    end
  end

endmodule

// File: rtl/osr_fifo.sv
// osr_fifo: parametrised PIO output shift register with TX-FIFO handshake,
// explicit PULL (blocking / non-blocking / if-empty), autopull with
// background refill, and a stall request to the instruction decoder.
// Optional feature macro: OSR_AUTOPULL_EN (autopull, threshold, OUT stall
// and background refill). Without it the autopull/pull_thresh inputs are
// ignored and "full" means the register is fully consumed.
//
// state           | meaning
// OSR_EMPTY       | count == W, every bit consumed
// OSR_PARTIAL     | count below the (effective) pull threshold
// OSR_FULL_THRESH | count >= threshold but < W
module osr_fifo
  import pio_pkg::*;
#(
  parameter int W  = OSR_W_DEFAULT,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          penable,
  input  logic          stalled,
  input  logic          dir,
  input  logic [CW-2:0] shift,
  input  logic          do_shift,
  input  logic          pull_req,
  input  logic          pull_block,
  input  logic          pull_ifempty,
  input  logic          autopull,
  input  logic [CW-2:0] pull_thresh,
  input  logic [W-1:0]  x_data,
  input  logic [W-1:0]  fifo_data,
  input  logic          fifo_valid,
  output logic          fifo_ready,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] shift_count,
  output logic          stall_req
);

  logic [W-1:0]  osr_q, osr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n;
  logic [CW-1:0] t_thr;
  logic [CW:0]   count_sum;
  logic [W-1:0]  sh_reg, sh_out;
  logic          adv;
  logic          full;
  logic          load_fifo, load_x, do_sh, stall_int;
  osr_state_t    state;

  assign adv = penable && !stalled;
  assign n   = CW'(zero_means_w(32'(shift), W));

`ifdef OSR_AUTOPULL_EN
  assign t_thr = CW'(zero_means_w(32'(pull_thresh), W));
`else
  // Threshold pinned at W so only a fully consumed register counts as full.
  logic unused_autopull_cfg;
  assign unused_autopull_cfg = ^{autopull, pull_thresh};
  assign t_thr = CW'(W);
`endif

  // EMPTY is always at or above the threshold since the threshold never exceeds W.
  assign state = (count_q == CW'(W)) ? OSR_EMPTY :
                 (count_q >= t_thr)  ? OSR_FULL_THRESH : OSR_PARTIAL;
  assign full  = (state != OSR_PARTIAL);

  assign count_sum = {1'b0, count_q} + {1'b0, n};

  osr_shifter #(.W(W), .CW(CW)) u_shifter (
    .reg_in    (osr_q),
    .n         (n),
    .dir       (dir),
    .reg_out   (sh_reg),
    .shift_out (sh_out)
  );

  // State register: shift contents and consumed-bit count.
  always_ff @(posedge clk) begin
    if (reset) begin
      osr_q   <= '0;
      count_q <= CW'(W);
    end else begin
      osr_q   <= osr_d;
      count_q <= count_d;
    end
  end

  // Next state: resolve PULL > OUT > background refill, then apply the action.
  always_comb begin
    load_fifo = 1'b0;
    load_x    = 1'b0;
    do_sh     = 1'b0;
    stall_int = 1'b0;
    if (adv) begin
      if (pull_req) begin
        if (!(pull_ifempty && !full)) begin
          if (fifo_valid) begin
            load_fifo = 1'b1;
          end else if (pull_block) begin
            stall_int = 1'b1;
          end else begin
            load_x = 1'b1;
          end
        end
      end else if (do_shift) begin
`ifdef OSR_AUTOPULL_EN
        if (autopull && full) begin
          // Refill first; the decoder re-issues the OUT next cycle.
          stall_int = 1'b1;
          load_fifo = fifo_valid;
        end else begin
          do_sh = 1'b1;
        end
`else
        do_sh = 1'b1;
`endif
      end
`ifdef OSR_AUTOPULL_EN
      else if (autopull && full && fifo_valid) begin
        load_fifo = 1'b1;
      end
`endif
    end

    osr_d   = osr_q;
    count_d = count_q;
    if (load_fifo) begin
      osr_d   = fifo_data;
      count_d = '0;
    end else if (load_x) begin
      osr_d   = x_data;
      count_d = '0;
    end else if (do_sh) begin
      osr_d   = sh_reg;
      count_d = (count_sum > (CW+1)'(W)) ? CW'(W) : count_sum[CW-1:0];
    end
  end

  // Outputs: handshake strobes are masked while reset is asserted.
  always_comb begin
    fifo_ready  = load_fifo && !reset;
    stall_req   = stall_int && !reset;
    dout        = do_shift ? sh_out : osr_q;
    shift_count = count_q;
  end

endmodule

// File: tb/tb_osr_fifo.sv
// tb_osr_fifo: directed scoreboard bench for osr_fifo (W = 32).
// Each step drives inputs, queues the expected combinational outputs and
// current count, then pops and compares them before the next clock edge.
module tb_osr_fifo;

  localparam int W  = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          penable, stalled, dir, do_shift, pull_req, pull_block;
  logic          pull_ifempty, autopull, fifo_valid;
  logic [CW-2:0] shift, pull_thresh;
  logic [W-1:0]  x_data, fifo_data;
  logic          fifo_ready, stall_req;
  logic [W-1:0]  dout;
  logic [CW-1:0] shift_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] e_dout;
    logic        e_ready;
    logic        e_stall;
    logic [31:0] e_count;
  } exp_t;

  exp_t exp_q[$];

  osr_fifo #(.W(W), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .penable      (penable),
    .stalled      (stalled),
    .dir          (dir),
    .shift        (shift),
    .do_shift     (do_shift),
    .pull_req     (pull_req),
    .pull_block   (pull_block),
    .pull_ifempty (pull_ifempty),
    .autopull     (autopull),
    .pull_thresh  (pull_thresh),
    .x_data       (x_data),
    .fifo_data    (fifo_data),
    .fifo_valid   (fifo_valid),
    .fifo_ready   (fifo_ready),
    .dout         (dout),
    .shift_count  (shift_count),
    .stall_req    (stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "/dout"},  dout, e.e_dout);
      chk({e.tag, "/ready"}, 32'(fifo_ready), 32'(e.e_ready));
      chk({e.tag, "/stall"}, 32'(stall_req), 32'(e.e_stall));
      chk({e.tag, "/count"}, 32'(shift_count), e.e_count);
    end
  endtask

  // Inputs are already driven (at a negedge); queue expectation, settle, compare, clock.
  task automatic step(input string tag, input logic [31:0] e_dout, input logic e_ready,
                      input logic e_stall, input logic [31:0] e_count);
    exp_t e;
    e.tag = tag; e.e_dout = e_dout; e.e_ready = e_ready;
    e.e_stall = e_stall; e.e_count = e_count;
    exp_q.push_back(e);
    #1;
    compare_head();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    penable = 1'b1; stalled = 1'b0; do_shift = 1'b0; pull_req = 1'b0;
    pull_block = 1'b0; pull_ifempty = 1'b0; fifo_valid = 1'b0;
  endtask

  task automatic pull_fifo(input logic [31:0] d);
    idle(); pull_req = 1'b1; pull_block = 1'b1; fifo_valid = 1'b1; fifo_data = d;
  endtask

  task automatic out_cmd(input logic d, input logic [4:0] s);
    idle(); do_shift = 1'b1; dir = d; shift = s;
  endtask

  initial begin
    reset = 1'b1; idle(); dir = 1'b0; shift = '0; autopull = 1'b0;
    pull_thresh = '0; x_data = '0; fifo_data = '0;

    // Reset, with a pull pending: no pop while reset is high.
    @(negedge clk);
    pull_fifo(32'h1111_1111);
    step("rst_pull", 32'h0, 1'b0, 1'b0, 32);
    reset = 1'b0; idle();
    step("rst_state", 32'h0, 1'b0, 1'b0, 32);

    // Blocking PULL with data available.
    pull_fifo(32'hDEAD_BEEF);
    step("pull_load", 32'h0, 1'b1, 1'b0, 32);
    idle();
    step("pull_after", 32'hDEAD_BEEF, 1'b0, 1'b0, 0);

    // Four right OUTs of 8 bits, then one more at saturation.
    out_cmd(1'b1, 5'd8); step("outr_1", 32'hEF, 1'b0, 1'b0, 0);
    idle();              step("outr_reg", 32'h00DE_ADBE, 1'b0, 1'b0, 8);
    out_cmd(1'b1, 5'd8); step("outr_2", 32'hBE, 1'b0, 1'b0, 8);
    out_cmd(1'b1, 5'd8); step("outr_3", 32'hAD, 1'b0, 1'b0, 16);
    out_cmd(1'b1, 5'd8); step("outr_4", 32'hDE, 1'b0, 1'b0, 24);
    out_cmd(1'b1, 5'd8); step("outr_sat", 32'h0, 1'b0, 1'b0, 32);
    idle();              step("outr_end", 32'h0, 1'b0, 1'b0, 32);

    // Full-width left OUT, then a further OUT that stays saturated.
    pull_fifo(32'h1234_5678); step("pull2", 32'h0, 1'b1, 1'b0, 32);
    out_cmd(1'b0, 5'd0); step("outl_32", 32'h1234_5678, 1'b0, 1'b0, 0);
    out_cmd(1'b0, 5'd4); step("outl_sat", 32'h0, 1'b0, 1'b0, 32);
    idle();              step("outl_end", 32'h0, 1'b0, 1'b0, 32);

    // Non-blocking PULL from empty FIFO loads x_data; blocking PULL stalls.
    idle(); pull_req = 1'b1; x_data = 32'h55;
    step("pull_x", 32'h0, 1'b0, 1'b0, 32);
    idle(); step("pull_x_reg", 32'h55, 1'b0, 1'b0, 0);
    idle(); pull_req = 1'b1; pull_block = 1'b1;
    step("pull_blk", 32'h55, 1'b0, 1'b1, 0);
    idle(); step("pull_blk_hold", 32'h55, 1'b0, 1'b0, 0);

    // pull_ifempty with count 4, threshold 32: no-op.
    out_cmd(1'b0, 5'd4); step("outl_4", 32'h0, 1'b0, 1'b0, 0);
    idle(); pull_req = 1'b1; pull_ifempty = 1'b1; fifo_valid = 1'b1;
    fifo_data = 32'hCAFE_F00D; pull_thresh = '0;
    step("ifempty_nop", 32'h550, 1'b0, 1'b0, 4);
    idle(); step("ifempty_hold", 32'h550, 1'b0, 1'b0, 4);

    // penable low for 3 cycles, then a stalled cycle: state frozen.
    autopull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_cmd(1'b0, 5'd4); penable = 1'b0; fifo_valid = 1'b1;
      step("penable_lo", 32'h0, 1'b0, 1'b0, 4);
    end
    idle(); stalled = 1'b1; pull_req = 1'b1; fifo_valid = 1'b1;
    step("stalled", 32'h550, 1'b0, 1'b0, 4);
    idle(); step("frozen", 32'h550, 1'b0, 1'b0, 4);

`ifdef OSR_AUTOPULL_EN
    // Autopull at threshold 16: stall while the FIFO is empty, one pop when it fills.
    pull_thresh = 5'd16;
    out_cmd(1'b1, 5'd12); step("ap_out12", 32'h550, 1'b0, 1'b0, 4);
    idle();               step("ap_at_thr", 32'h0, 1'b0, 1'b0, 16);
    for (int i = 0; i < 3; i++) begin
      out_cmd(1'b1, 5'd8);
      step("ap_stall_empty", 32'h0, 1'b0, 1'b1, 16);
    end
    out_cmd(1'b1, 5'd8); fifo_valid = 1'b1; fifo_data = 32'hA5A5_A5A5;
    step("ap_pop", 32'h0, 1'b1, 1'b1, 16);
    out_cmd(1'b1, 5'd8); step("ap_retry", 32'hA5, 1'b0, 1'b0, 0);
    idle();              step("ap_after", 32'h00A5_A5A5, 1'b0, 1'b0, 8);
    // Background refill once count reaches a threshold of 8.
    pull_thresh = 5'd8;
    idle(); fifo_valid = 1'b1; fifo_data = 32'h0F0F_0F0F;
    step("bg_refill", 32'h00A5_A5A5, 1'b1, 1'b0, 8);
    idle(); step("bg_after", 32'h0F0F_0F0F, 1'b0, 1'b0, 0);
`else
    // Without autopull support: OUT at count 32 never stalls, no refill.
    pull_thresh = 5'd16;
    out_cmd(1'b1, 5'd0); step("na_out32", 32'h550, 1'b0, 1'b0, 4);
    out_cmd(1'b1, 5'd4); fifo_valid = 1'b1;
    step("na_nostall", 32'h0, 1'b0, 1'b0, 32);
    idle(); fifo_valid = 1'b1; fifo_data = 32'h0F0F_0F0F;
    step("na_norefill", 32'h0, 1'b0, 1'b0, 32);
    idle(); pull_req = 1'b1; pull_ifempty = 1'b1; fifo_valid = 1'b1;
    step("na_ifempty_full", 32'h0, 1'b1, 1'b0, 32);
    idle(); step("na_after", 32'h0F0F_0F0F, 1'b0, 1'b0, 0);
`endif
    autopull = 1'b0; pull_thresh = '0;

    // Reset in the middle of a blocking-PULL stall.
    idle(); pull_req = 1'b1; pull_block = 1'b1;
    step("stall_pre", 32'h0F0F_0F0F, 1'b0, 1'b1, 0);
    reset = 1'b1;
    step("stall_rst", 32'h0F0F_0F0F, 1'b0, 1'b0, 0);
    reset = 1'b0; idle();
    step("post_rst", 32'h0, 1'b0, 1'b0, 32);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/osr_fifo.md
# osr_fifo

Parametrised output shift register for the PIO state machine, successor to the fixed 32-bit OSR. It adds a TX-FIFO valid/ready interface, explicit PULL (blocking, non-blocking, if-empty), threshold-based autopull with background refill, and a stall request back to the instruction decoder. It sits between the per-SM TX FIFO and the OUT/PULL execution path.

## Interface
- `W`, 32: register width; must be ≥ 2.
- `CW`, `$clog2(W)+1`: width of the shift count.
- clk  input  1  system clock; one clock domain only.
- reset  input  1  synchronous, active-high reset.
- penable  input  1  SM clock-divider enable; state changes only when high.
- stalled  input  1  SM stalled elsewhere; state is frozen when high.
- dir  input  1  shift direction: 0 left (MSB out), 1 right (LSB out).
- shift  input  CW-1  OUT bit count; 0 means W.
- do_shift  input  1  OUT instruction executing.
- pull_req  input  1  PULL instruction executing.
- pull_block  input  1  PULL blocks when the FIFO is empty.
- pull_ifempty  input  1  PULL is a no-op unless count ≥ threshold.
- autopull  input  1  autopull enable.
- pull_thresh  input  CW-1  autopull threshold; 0 means W.
- x_data  input  W  value loaded by a non-blocking PULL when the FIFO is empty.
- fifo_data  input  W  TX FIFO head.
- fifo_valid  input  1  TX FIFO not empty.
- fifo_ready  output  1  pop strobe; combinational; high only in a load cycle.
- dout  output  W  during do_shift, the shifted-out bits right-aligned with upper bits zero; otherwise the register contents.
- shift_count  output  CW  bits consumed, 0..W; W means empty.
- stall_req  output  1  combinational; the decoder must hold the current instruction.

## Operation
- The block advances only in cycles where `adv = penable && !stalled`. In other cycles `fifo_ready=0`, `stall_req=0`, and the state holds.
- `n = (shift==0) ? W : shift`. `T = (pull_thresh==0) ? W : pull_thresh`. `full = (count ≥ T)`.
- Priority when `adv`: pull_req, then do_shift, then background refill.
- **PULL**
  - If `pull_ifempty && !full`: no-op, no stall.
  - Else if `fifo_valid`: load `fifo_data`, set count to 0, `fifo_ready=1`.
  - Else if `pull_block`: `stall_req=1`, no state change.
  - Else: load `x_data`, set count to 0.
- **OUT with autopull and `full`**
  - `stall_req=1`.
  - If `fifo_valid`: load `fifo_data`, set count to 0, `fifo_ready=1`. The shift does not occur; the decoder retries next cycle.
- **OUT otherwise**
  - Left: `reg <= reg << n`, dout = old `reg[W-1 -: n]`.
  - Right: `reg <= reg >> n`, dout = old `reg[n-1:0]`.
  - `n == W` clears the register.
  - `count <= min(count+n, W)`, computed at CW+1 bits to avoid overflow.
- **Background refill**
  - Condition: `adv`, no pull_req and no do_shift, autopull set, `full`, and `fifo_valid`.
  - Action: load `fifo_data`, set count to 0, `fifo_ready=1`.
- At most one FIFO pop per cycle. The register never loads without `fifo_ready`, except for the `x_data` path.
- The block has three states: EMPTY (`count==W`), PARTIAL, FULL_THRESH (`full`, count<W).
  - Any load goes to count 0.
  - Shifts move the count upward, saturating at W.

## Timing
- Reset values: register 0, shift_count = W, fifo_ready = 0, stall_req = 0, dout = 0.
- Loads and shifts take effect on the next rising edge.
- dout, fifo_ready and stall_req are combinational from the current state and inputs.
- Autopull stall costs exactly 1 cycle when the FIFO is non-empty. It lasts until `fifo_valid` when the FIFO is empty.
- `reset` mid-stall clears the state. fifo_ready is low during reset.
- `penable` low for any number of cycles preserves the state exactly.
- pull_req and do_shift asserted together: pull_req wins. The shift is ignored; the decoder never issues both.

## Configuration
- `OSR_AUTOPULL_EN` defined: autopull, pull_thresh, the OUT stall and background refill behave as above.
- Not defined: the autopull and pull_thresh inputs are ignored.
  - `full` is computed as `count == W` for pull_ifempty only.
  - OUT never stalls; background refill is absent.

## Structure
- Package `pio_pkg` holds:
  - the direction constants `DIR_LEFT=0` and `DIR_RIGHT=1`;
  - the default `W`;
  - the helper that maps an encoded count of 0 to W.
- Sub-module `osr_shifter` is combinational. Inputs: reg, n, dir. Outputs: the new register value and the right-aligned shift-out. The top module holds the count, priority logic and handshake.

## Test plan
- Reset, then `fifo_data=0xDEADBEEF`, valid, blocking PULL: fifo_ready=1 for 1 cycle, then register 0xDEADBEEF, count 0.
- Right OUT with shift=8 after that load: dout=0xEF, register 0x00DEADBE, count 8. Four OUTs bring count to 32, saturating.
- Left OUT with shift=0 (32) on 0x12345678: dout=0x12345678, register 0, count 32. A further OUT with shift=4 keeps count at 32.
- Autopull, thresh=16, count=16, OUT with FIFO empty: stall_req held high. Asserting fifo_valid with 0xA5A5A5A5 gives one pop, count 0, stall drops; the next OUT proceeds.
- Non-blocking PULL with FIFO empty and `x_data=0x55`: register 0x55, no pop. Blocking PULL: stall_req=1, no change. `pull_ifempty` with count 4, thresh 32: no-op.
- `penable=0` for 3 cycles with do_shift held: no state change, stall_req=0. Build without `OSR_AUTOPULL_EN`: OUT at count 32 never stalls.
